// File: rtl/button_pio_pkg.sv
// Purpose: shared register map and edge-mode encodings for the button PIO.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package button_pio_pkg;

    // Avalon-MM register map (word addresses)
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_RSVD    = 2'd2;
    localparam logic [1:0] ADDR_EDGE    = 2'd3;

    // EDGE_MODE encodings
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // True when a prev->cur change of one debounced bit is an edge of interest.
    function automatic logic edge_hit(input int mode, input logic prev, input logic cur);
        case (mode)
            EDGE_RISING:  return ~prev & cur;
            EDGE_FALLING: return prev & ~cur;
            default:      return prev ^ cur;
        endcase
    endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// Purpose: 2-flop synchroniser plus saturating debounce counter for one input bit.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles before o_level follows (DEBOUNCE_CYCLES=0: 3 cycles).
// Backpressure: none; free-running every cycle.
// Ports: clk, reset (sync, active-high), i_async (raw pin), o_level (debounced level).
module pio_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_level
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; keep a 1-bit stub when debounce is bypassed.
    localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

    logic          r_meta;
    logic          r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            if (DEBOUNCE_CYCLES == 0) begin
                r_level <= r_sync;
                r_cnt   <= '0;
            end else if (r_sync == r_level) begin
                // any cycle of agreement abandons the pending change
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                // this is the DEBOUNCE_CYCLES-th consecutive differing cycle
                r_level <= r_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/button_pio_irq.sv
// Purpose: Avalon-MM PIO for push buttons: debounced data, edge capture, masked level IRQ.
// Latency: readdata 1 cycle after chipselect&read, no wait states; irq 1 cycle after register change.
// Backpressure: none; slave always accepts, reads and writes complete in one cycle.
// Ports: clk, reset (sync, active-high), address/chipselect/read/write/writedata/readdata (Avalon-MM),
//        in_port (async button inputs), irq (level interrupt).
module button_pio_irq
    import button_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] r_level_d;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] w_hit;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rdata;
    logic             w_rd;
    logic             w_wr;
    logic             w_unused_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            pio_debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .reset  (reset),
                .i_async(in_port[gi]),
                .o_level(w_level[gi])
            );
        end
    endgenerate

    assign w_rd = chipselect & read;
    assign w_wr = chipselect & write;

    // Upper writedata bits beyond WIDTH carry no meaning for any register.
    assign w_unused_wdata = ^writedata;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_hit[i] = edge_hit(EDGE_MODE, r_level_d[i], w_level[i]);
        end
    end

    assign w_clr = (w_wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    // Read mux sees pre-write state, so a simultaneous write returns old contents.
    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA:    w_rdata[WIDTH-1:0] = w_level;
            ADDR_IRQMASK: w_rdata[WIDTH-1:0] = r_irqmask;
            ADDR_EDGE:    w_rdata[WIDTH-1:0] = r_edge;
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // r_level_d clears with the levels so a reset-forced drop is never seen as an edge
            r_level_d <= '0;
            r_irqmask <= '0;
            r_edge    <= '0;
            readdata  <= '0;
            irq       <= 1'b0;
        end else begin
            r_level_d <= w_level;
            // new edge wins over write-1-to-clear on the same bit
            r_edge    <= (r_edge & ~w_clr) | w_hit;
            if (w_wr && address == ADDR_IRQMASK) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
            if (w_rd) begin
                readdata <= w_rdata;
            end
            irq <= |(r_edge & r_irqmask);
        end
    end

endmodule

// File: tb/tb_button_pio_irq.sv
// Purpose: self-checking bench; two DUTs (debounced falling-edge, bypassed any-edge) against a behavioural model.
// Latency: model predicts registered outputs cycle by cycle; checks sampled on falling clock edges.
// Backpressure: n/a.
module tb_button_pio_irq;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata_a;
    logic [31:0] readdata_b;
    logic        irq_a;
    logic        irq_b;

    int  checks = 0;
    int  errs   = 0;
    bit  chk_en = 1'b0;

    button_pio_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1)) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata_a),
        .in_port(in_port), .irq(irq_a)
    );

    button_pio_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_MODE(2)) dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata_b),
        .in_port(in_port), .irq(irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Index 0 models dut_a, index 1 models dut_b.
    logic [3:0]  m_d1, m_d2;          // in_port seen 1 and 2 cycles ago
    logic [3:0]  m_win [2][4];        // most recent synchronised samples, [0] newest
    logic [3:0]  m_deb [2];
    logic [3:0]  m_debp [2];
    logic [3:0]  m_mask [2];
    logic [3:0]  m_ec [2];
    logic [31:0] m_rd [2];
    logic        m_irq [2];

    function automatic int dbc(input int k);
        return (k == 0) ? 4 : 0;
    endfunction

    function automatic int emode(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic logic [3:0] hits(input int mode, input logic [3:0] p, input logic [3:0] c);
        case (mode)
            0:       return c & ~p;
            1:       return p & ~c;
            default: return p ^ c;
        endcase
    endfunction

    task automatic model_step();
        logic [3:0] nd, clr, reg_v;
        logic       all_d;
        if (reset) begin
            m_d1 = '0;
            m_d2 = '0;
            for (int k = 0; k < 2; k++) begin
                for (int j = 0; j < 4; j++) m_win[k][j] = '0;
                m_deb[k] = '0; m_debp[k] = '0; m_mask[k] = '0; m_ec[k] = '0;
                m_rd[k] = '0;  m_irq[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int j = 3; j > 0; j--) m_win[k][j] = m_win[k][j-1];
                m_win[k][0] = m_d2;
                nd = m_deb[k];
                if (dbc(k) == 0) begin
                    nd = m_d2;
                end else begin
                    // accept a bit once the last D samples all disagree with the held level
                    for (int b = 0; b < 4; b++) begin
                        all_d = 1'b1;
                        for (int j = 0; j < dbc(k); j++)
                            if (m_win[k][j][b] == m_deb[k][b]) all_d = 1'b0;
                        if (all_d) nd[b] = m_d2[b];
                    end
                end
                case (address)
                    2'd0:    reg_v = m_deb[k];
                    2'd1:    reg_v = m_mask[k];
                    2'd2:    reg_v = 4'd0;
                    default: reg_v = m_ec[k];
                endcase
                if (chipselect && read) m_rd[k] = {28'd0, reg_v};
                clr = (chipselect && write && address == 2'd3) ? writedata[3:0] : 4'd0;
                m_irq[k] = |(m_ec[k] & m_mask[k]);
                m_ec[k]  = (m_ec[k] & ~clr) | hits(emode(k), m_debp[k], m_deb[k]);
                if (chipselect && write && address == 2'd1) m_mask[k] = writedata[3:0];
                m_debp[k] = m_deb[k];
                m_deb[k]  = nd;
            end
            m_d2 = m_d1;
            m_d1 = in_port;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("rd_a",  readdata_a, m_rd[0]);
            chk("irq_a", {31'd0, irq_a}, {31'd0, m_irq[0]});
            chk("rd_b",  readdata_b, m_rd[1]);
            chk("irq_b", {31'd0, irq_b}, {31'd0, m_irq[1]});
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] da, output logic [31:0] db);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        da = readdata_a; db = readdata_b;
        chipselect = 1'b0; read = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          trans;
        logic        last;
        reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = 2'd0; writedata = 32'd0; in_port = 4'h0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_rd_a", readdata_a, 32'h0);
        chk("reset_irq_a", {31'd0, irq_a}, 32'h0);
        chk("reset_rd_b", readdata_b, 32'h0);
        chk("reset_irq_b", {31'd0, irq_b}, 32'h0);

        // press all buttons: level accepted after 2 sync + 4 stable cycles
        in_port = 4'hF;
        repeat (5) @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = 2'd0;
        @(negedge clk);
        chk("data_before_accept", readdata_a, 32'h0);
        @(negedge clk);
        chk("data_accepted", readdata_a, 32'h0000000F);
        chk("model_data", m_rd[0], 32'h0000000F);
        chipselect = 1'b0; read = 1'b0;

        // bounce on bit0, then settle low
        bus_write(2'd3, 32'hF);
        chipselect = 1'b1; read = 1'b1; address = 2'd0;
        last  = readdata_a[0];
        trans = 0;
        for (int i = 0; i < 34; i++) begin
            if (i < 20 && (i % 2) == 0) in_port[0] = ~in_port[0];
            if (i == 20) in_port[0] = 1'b0;
            @(negedge clk);
            if (readdata_a[0] != last) trans++;
            last = readdata_a[0];
        end
        chipselect = 1'b0; read = 1'b0;
        chk("bounce_transitions", trans, 1);
        bus_read(2'd3, ra, rb);
        chk("bounce_edge", ra, 32'h1);

        // masked interrupt on bit1, then write-1-to-clear
        bus_write(2'd3, 32'hF);
        bus_write(2'd1, 32'h2);
        in_port = 4'hC;
        repeat (10) @(negedge clk);
        chk("irq_set", {31'd0, irq_a}, 32'h1);
        bus_write(2'd3, 32'h2);
        chk("irq_hold_one_cycle", {31'd0, irq_a}, 32'h1);
        @(negedge clk);
        chk("irq_cleared", {31'd0, irq_a}, 32'h0);
        bus_read(2'd3, ra, rb);
        chk("edge_cleared", ra, 32'h0);

        // same-cycle clear and new edge on bit2
        bus_write(2'd1, 32'h4);
        in_port = 4'h8;
        repeat (10) @(negedge clk);
        chk("irq_bit2", {31'd0, irq_a}, 32'h1);
        in_port = 4'hC;
        repeat (10) @(negedge clk);
        in_port = 4'h8;
        repeat (6) @(negedge clk);
        bus_write(2'd3, 32'h4);
        chk("irq_same_cycle", {31'd0, irq_a}, 32'h1);
        bus_read(2'd3, ra, rb);
        chk("edge_set_priority", ra, 32'h4);
        chk("irq_after_priority", {31'd0, irq_a}, 32'h1);

        // reset at debounce count 3 of 4
        in_port = 4'hF;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_rd_a", readdata_a, 32'h0);
        chk("midreset_irq_a", {31'd0, irq_a}, 32'h0);
        chk("midreset_rd_b", readdata_b, 32'h0);
        chk("midreset_irq_b", {31'd0, irq_b}, 32'h0);
        chipselect = 1'b1; read = 1'b1; address = 2'd0;
        repeat (6) @(negedge clk);
        chk("restart_not_yet", readdata_a, 32'h0);
        @(negedge clk);
        chk("restart_accepted", readdata_a, 32'hF);
        chipselect = 1'b0; read = 1'b0;
        bus_read(2'd1, ra, rb);
        chk("mask_after_reset", ra, 32'h0);
        bus_read(2'd3, ra, rb);
        chk("no_capture_on_reset", ra, 32'h0);

        // one-cycle pulse on bit3: rejected by debounce, caught by bypass/any-edge unit
        in_port = 4'h7;
        repeat (8) @(negedge clk);
        bus_write(2'd3, 32'hF);
        repeat (2) @(negedge clk);
        in_port = 4'hF;
        @(negedge clk);
        in_port = 4'h7;
        repeat (8) @(negedge clk);
        bus_read(2'd3, ra, rb);
        chk("pulse_rejected_a", ra, 32'h0);
        chk("pulse_any_edge_b", rb, 32'h8);
        bus_write(2'd2, 32'hFFFFFFFF);
        bus_read(2'd2, ra, rb);
        chk("reserved_a", ra, 32'h0);
        chk("reserved_b", rb, 32'h0);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 9) == 0) in_port = 4'($urandom);
            chipselect = 1'($urandom_range(0, 1));
            read       = 1'($urandom_range(0, 1));
            write      = ($urandom_range(0, 3) == 0);
            address    = 2'($urandom);
            writedata  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
            @(negedge clk);
        end
        reset = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
